// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu_if
//  Brief    : Data-memory request/acknowledge bus between the MEM stage and
//             the data memory.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_stage_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [3:0]            dmem_be;
    logic                  dmem_ack;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu
//  Brief    : RV32I memory stage: byte-lane steering, load extension, wait-state
//             handshake with upstream stall, and the MEM/WB register.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   RegWriteM,
    input  wire  [1:0]            ResultSrcM,
    input  wire                   MemWriteM,
    input  wire  [2:0]            Funct3M,
    input  wire  [DATA_WIDTH-1:0] ALUResultM,
    input  wire  [DATA_WIDTH-1:0] WriteDataM,
    input  wire  [DATA_WIDTH-1:0] PCPlus4M,
    input  wire  [4:0]            RdM,
    mem_stage_lsu_if.master       dmem,
    output logic                  StallM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic [4:0]            RdW,
    output logic                  MisalignW
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] c_SRC_LOAD = 2'b01;

    state_t r_state;
    state_t w_state_nxt;

    logic                  w_is_load;
    logic                  w_acc;
    logic                  w_f3_legal;
    logic                  w_misalign;
    logic                  w_bad;
    logic                  w_req;
    logic                  w_stall;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rd_shift_b;
    logic [DATA_WIDTH-1:0] w_rd_shift_h;
    logic [7:0]            w_rd_byte;
    logic [15:0]           w_rd_half;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_is_load = (ResultSrcM == c_SRC_LOAD);
    assign w_acc     = MemWriteM | w_is_load;

    // Unsigned sizes (100/101) exist only for loads.
    always_comb begin
        w_f3_legal = 1'b0;
        w_misalign = 1'b0;
        case (Funct3M)
            3'b000: w_f3_legal = 1'b1;
            3'b001: begin
                w_f3_legal = 1'b1;
                w_misalign = ALUResultM[0];
            end
            3'b010: begin
                w_f3_legal = 1'b1;
                w_misalign = |ALUResultM[1:0];
            end
            3'b100: w_f3_legal = ~MemWriteM;
            3'b101: begin
                w_f3_legal = ~MemWriteM;
                w_misalign = ALUResultM[0];
            end
            default: w_f3_legal = 1'b0;
        endcase
    end

    assign w_bad   = w_acc & (~w_f3_legal | w_misalign);
    assign w_req   = w_acc & ~w_bad & ~rst;
    assign w_stall = w_req & ~dmem.dmem_ack;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALUResultM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
        endcase
        if (!w_req) begin
            w_be = 4'b0000;
        end
    end

    assign w_rd_shift_b = dmem.dmem_rdata >> {ALUResultM[1:0], 3'b000};
    assign w_rd_shift_h = dmem.dmem_rdata >> {ALUResultM[1], 4'b0000};
    assign w_rd_byte    = w_rd_shift_b[7:0];
    assign w_rd_half    = w_rd_shift_h[15:0];

    always_comb begin
        w_load_data = dmem.dmem_rdata;
        case (Funct3M)
            3'b000:  w_load_data = {{(DATA_WIDTH-8){w_rd_byte[7]}}, w_rd_byte};
            3'b001:  w_load_data = {{(DATA_WIDTH-16){w_rd_half[15]}}, w_rd_half};
            3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_rd_byte};
            3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_rd_half};
            default: w_load_data = dmem.dmem_rdata;
        endcase
    end

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = MemWriteM;
    assign dmem.dmem_addr  = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
    assign dmem.dmem_wdata = w_wdata;
    assign dmem.dmem_be    = w_be;
    assign StallM          = w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req && !dmem.dmem_ack) w_state_nxt = ST_WAIT;
            ST_WAIT: if (dmem.dmem_ack)           w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A stalled cycle leaves a bubble behind; a rejected access only raises the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= 5'd0;
            MisalignW  <= 1'b0;
        end else if (w_stall) begin
            RegWriteW  <= 1'b0;
            MisalignW  <= 1'b0;
        end else if (w_bad) begin
            RegWriteW  <= 1'b0;
            MisalignW  <= 1'b1;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= w_is_load ? w_load_data : '0;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            MisalignW  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_lsu
//  Brief    : Randomized scoreboard bench for mem_stage_lsu.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic        MemWriteM = 1'b0;
    logic [2:0]  Funct3M = 3'b000;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] PCPlus4M = '0;
    logic [4:0]  RdM = '0;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic        MisalignW;

    mem_stage_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dmem_bus ();

    mem_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .RdM        (RdM),
        .dmem       (dmem_bus),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .MisalignW  (MisalignW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        ack;
        logic [31:0] rdata;
    } in_t;

    typedef struct {
        logic        req;
        logic        we;
        logic        stall;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        chk_wdata;
        logic [31:0] wdata;
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdw;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        mis;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t w_m;
    exp_t cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Access size in bytes (0 = unknown encoding), signedness, and legality.
    function automatic void decode(input in_t x, output int size, output bit sgn,
                                   output bit acc, output bit badacc);
        bit legal, misal;
        int off;
        size = 0;
        sgn  = 1'b0;
        case (x.f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: size = 0;
        endcase
        acc   = x.mw || (x.rs == 2'd1);
        legal = (size != 0) && !(x.mw && x.f3 >= 3'd4);
        off   = int'(x.alu % 4);
        misal = 1'b0;
        if (size != 0) misal = (off % size) != 0;
        badacc = acc && (!legal || misal);
    endfunction

    task automatic apply(input in_t x);
        exp_t e;
        int size, off;
        bit sgn, acc, badacc, req;
        longint unsigned r, v, mask;
        @(posedge clk);
        #2;
        rst        = x.rst;
        RegWriteM  = x.rw;
        ResultSrcM = x.rs;
        MemWriteM  = x.mw;
        Funct3M    = x.f3;
        ALUResultM = x.alu;
        WriteDataM = x.wd;
        PCPlus4M   = x.pc4;
        RdM        = x.rd;
        dmem_bus.dmem_ack   = x.ack;
        dmem_bus.dmem_rdata = x.rdata;

        decode(x, size, sgn, acc, badacc);
        off = int'(x.alu % 4);
        req = acc && !badacc && !x.rst;
        e = w_m;
        e.req   = req;
        e.we    = x.mw;
        e.stall = req && !x.ack;
        e.addr  = x.alu - 32'(off);
        e.be    = req ? 4'(((1 << size) - 1) << off) : 4'd0;
        e.chk_wdata = req && x.mw;
        e.wdata = '0;
        v = 0;
        if (size != 0) begin
            for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = x.wd[8*(k % size) +: 8];
            r    = 64'(x.rdata);
            mask = (64'd1 << (8 * size)) - 1;
            v    = (r >> (8 * off)) & mask;
            if (sgn && v[8*size-1]) v = v | ~mask;
        end

        if (x.rst) begin
            w_m.rw = 0; w_m.rs = 0; w_m.alu = 0; w_m.rdw = 0;
            w_m.pc4 = 0; w_m.rd = 0; w_m.mis = 0;
        end else if (e.stall) begin
            w_m.rw = 0; w_m.mis = 0;
        end else if (badacc) begin
            w_m.rw = 0; w_m.mis = 1;
        end else begin
            w_m.rw  = x.rw;
            w_m.rs  = x.rs;
            w_m.alu = x.alu;
            w_m.rdw = (x.rs == 2'd1) ? v[31:0] : 32'd0;
            w_m.pc4 = x.pc4;
            w_m.rd  = x.rd;
            w_m.mis = 0;
        end
        e.rw = w_m.rw; e.rs = w_m.rs; e.alu = w_m.alu; e.rdw = w_m.rdw;
        e.pc4 = w_m.pc4; e.rd = w_m.rd; e.mis = w_m.mis;
        q.push_back(e);
    endtask

    function automatic in_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                               input logic [2:0] f3, input logic [31:0] alu,
                               input logic [31:0] wd);
        in_t x;
        x.rst = 0; x.rw = rw; x.rs = rs; x.mw = mw; x.f3 = f3; x.alu = alu; x.wd = wd;
        x.pc4 = $urandom; x.rd = 5'($urandom); x.ack = 0; x.rdata = 0;
        return x;
    endfunction

    // Memory answers after 'waits' request cycles; ack outside a request is noise.
    task automatic issue(input in_t x, input int waits, input logic [31:0] rdata);
        in_t y;
        int size;
        bit sgn, acc, badacc;
        decode(x, size, sgn, acc, badacc);
        if (acc && !badacc) begin
            for (int c = 0; c <= waits; c++) begin
                y = x;
                y.ack   = (c == waits);
                y.rdata = (c == waits) ? rdata : $urandom;
                apply(y);
            end
        end else begin
            y = x;
            y.ack   = 1'($urandom);
            y.rdata = $urandom;
            apply(y);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                cur = q.pop_front();
                chk("dmem_req", 32'(dmem_bus.dmem_req), 32'(cur.req));
                chk("StallM", 32'(StallM), 32'(cur.stall));
                chk("dmem_we", 32'(dmem_bus.dmem_we), 32'(cur.we));
                chk("dmem_addr", dmem_bus.dmem_addr, cur.addr);
                chk("dmem_be", 32'(dmem_bus.dmem_be), 32'(cur.be));
                if (cur.chk_wdata) chk("dmem_wdata", dmem_bus.dmem_wdata, cur.wdata);
                @(posedge clk);
                #1;
                chk("RegWriteW", 32'(RegWriteW), 32'(cur.rw));
                chk("ResultSrcW", 32'(ResultSrcW), 32'(cur.rs));
                chk("ALUResultW", ALUResultW, cur.alu);
                chk("ReadDataW", ReadDataW, cur.rdw);
                chk("PCPlus4W", PCPlus4W, cur.pc4);
                chk("RdW", 32'(RdW), 32'(cur.rd));
                chk("MisalignW", 32'(MisalignW), 32'(cur.mis));
            end
        end
    end

    initial begin
        in_t x, y;
        int kind;
        logic [2:0] f3;
        logic [2:0] legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;
        w_m = '{default: '0};

        x = mk(0, 2'b00, 0, 3'b000, 32'h0, 32'h0);
        x.rst = 1;
        apply(x);
        apply(x);

        issue(mk(0, 2'b00, 1, 3'b010, 32'h100, 32'hDEADBEEF), 0, 0);
        issue(mk(1, 2'b01, 0, 3'b000, 32'h103, 0), 0, 32'h80FFFF7F);
        issue(mk(1, 2'b01, 0, 3'b100, 32'h103, 0), 0, 32'h80FFFF7F);
        issue(mk(1, 2'b01, 0, 3'b010, 32'h200, 0), 3, 32'hCAFEF00D);
        issue(mk(0, 2'b00, 1, 3'b001, 32'h202, 32'h0000ABCD), 1, 0);
        issue(mk(0, 2'b00, 1, 3'b000, 32'h201, 32'h00000012), 0, 0);
        issue(mk(1, 2'b01, 0, 3'b010, 32'h101, 0), 0, 0);
        issue(mk(1, 2'b01, 0, 3'b001, 32'h003, 0), 0, 0);

        // Reset lands while an access is still waiting for its ack.
        y = mk(1, 2'b01, 0, 3'b010, 32'h200, 0);
        apply(y);
        apply(y);
        y.rst = 1;
        apply(y);
        issue(mk(1, 2'b00, 0, 3'b000, 32'h55, 0), 0, 0);

        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 3));
            f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
            case (kind)
                0:       x = mk(1'($urandom), 2'b00, 0, f3, $urandom, $urandom);
                1:       x = mk(1'($urandom), 2'b01, 0, f3, $urandom, $urandom);
                2:       x = mk(1'($urandom), 2'b00, 1, f3, $urandom, $urandom);
                default: x = mk(1'($urandom), 2'b10, 0, f3, $urandom, $urandom);
            endcase
            issue(x, int'($urandom_range(0, 3)), $urandom);
        end

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-access stage of the 5-stage pipelined RV32I core. It consumes the EX/MEM register outputs (M-suffixed signals) and drives the data-memory port, with a req/ack handshake that tolerates wait states. It performs byte-lane steering for SB/SH/SW and extraction with sign or zero extension for LB/LH/LW/LBU/LHU. It owns the MEM/WB register (W-suffixed outputs) and raises a stall to freeze all upstream stages while a memory access is outstanding.

Parameters:
DATA_WIDTH, 32, datapath/word width; only 32 is supported.
ADDR_WIDTH, 32, data-memory byte-address width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
RegWriteM  in  1  instruction writes rd
ResultSrcM  in  2  00 ALU result, 01 load data, 10 PC+4
MemWriteM  in  1  store instruction
Funct3M  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALUResultM  in  DATA_WIDTH  effective byte address / ALU result
WriteDataM  in  DATA_WIDTH  store data (rs2)
PCPlus4M  in  DATA_WIDTH  PC+4 for JAL/JALR
RdM  in  5  destination register
dmem_req  out  1  access request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
dmem_wdata  out  DATA_WIDTH  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle
dmem_rdata  in  DATA_WIDTH  read word
StallM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
RegWriteW  out  1  registered
ResultSrcW  out  2  registered
ALUResultW  out  DATA_WIDTH  registered
ReadDataW  out  DATA_WIDTH  registered, extended load data
PCPlus4W  out  DATA_WIDTH  registered
RdW  out  5  registered
MisalignW  out  1  registered one-cycle illegal/misaligned access flag

Behaviour:
- Access condition: acc = MemWriteM | (ResultSrcM == 01).
- Legality:
  - Legal Funct3 for a load: 000, 001, 010, 100, 101. Legal for a store: 000, 001, 010.
  - Misaligned: H/HU with addr[0] = 1; W with addr[1:0] != 0.
  - bad = acc & (illegal Funct3 | misaligned).
- FSM has two states: IDLE and WAIT. Reset state is IDLE.
- dmem_req = acc & ~bad & ~rst, combinational. It is asserted in IDLE and in WAIT.
- dmem_we = MemWriteM. dmem_addr = {ALUResultM[ADDR_WIDTH-1:2], 2'b00}.
- StallM = dmem_req & ~dmem_ack, combinational.
  - A zero-wait ack in IDLE completes the access with no stall.
- Transitions:
  - IDLE -> WAIT when dmem_req & ~dmem_ack.
  - WAIT -> IDLE when dmem_ack.
  - WAIT holds otherwise.
- While StallM = 1, upstream holds the M inputs stable. No timeout.
- Store steering:
  - SB: be = 0001 << addr[1:0]; wdata = byte[7:0] replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011; wdata = half[15:0] replicated ×2.
  - SW: be = 1111; wdata = WriteDataM.
  - be = 0000 when no request is made.
- Load extraction:
  - byte = rdata >> (8·addr[1:0]); half = rdata >> (16·addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- MEM/WB register, updated every cycle:
  - If rst: all W outputs become 0.
  - Else if StallM: insert a bubble. RegWriteW <= 0 and MisalignW <= 0; other W regs hold.
  - Else if bad: RegWriteW <= 0 and MisalignW <= 1; no memory request is made.
  - Else: capture RegWriteM, ResultSrcM, ALUResultM, PCPlus4M and RdM. ReadDataW <= extracted load data when ResultSrcM == 01, otherwise 0. MisalignW <= 0.
- Latency:
  - Non-memory ops and zero-wait accesses: 1 cycle M -> W.
  - Access acked N cycles after the first request: N+1 cycles, with StallM high for N cycles.
- Reset mid-WAIT: dmem_req is forced low while rst = 1. The next cycle is IDLE with all W outputs = 0. The memory side must discard an un-acked request.
- dmem_ack with no request is ignored.

Test Plan:
1. SW, addr 0x100, data 0xDEADBEEF, ack in the same cycle -> req = 1, we = 1, addr 0x100, be 1111, wdata 0xDEADBEEF, StallM = 0; next cycle RegWriteW = 0, MisalignW = 0.
2. LB at 0x103, rdata 0x80FF_FF7F, immediate ack -> ReadDataW 0xFFFFFF80, RegWriteW = 1; the same access as LBU -> ReadDataW 0x00000080.
3. LW at 0x200, ack 3 cycles after the request -> StallM high for exactly 3 cycles with addr/req stable; RegWriteW = 0 for those cycles; then one cycle with ReadDataW = rdata and RegWriteW = 1.
4. SH at 0x202, data 0x0000ABCD -> be 1100, wdata 0xABCDABCD; SB at 0x201, data 0x12 -> be 0010, wdata 0x12121212.
5. LW at 0x101 and LH at 0x003 -> no dmem_req, StallM = 0; MisalignW = 1 for one cycle; RegWriteW = 0.
6. rst asserted while in WAIT (ack withheld) -> dmem_req = 0 during rst; after rst deasserts, FSM is IDLE, StallM = 0 and all W outputs are 0. Also check an ALU op (ResultSrcM = 00, ALUResultM 0x55): ALUResultW = 0x55 after 1 cycle, with no request.
